// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// if_fetch_unit: RV32I fetch stage: PC, credit-limited in-order imem requests, instruction buffer feeding ID.
// Head of the buffer is presented combinationally; IF_JAL_PREDICT_EN redirects fetch on a returned JAL.
module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc_out,
    output logic [31:0]     if_instruction
);
    localparam int              PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [CW:0]     CREDITS    = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST       = PW'(FIFO_DEPTH - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ins;
    } fetch_ent_t;

    logic [XLEN-1:0]                  pc_q, pc_d;
    logic [CW-1:0]                    out_q, out_d;
    logic [CW-1:0]                    drop_q, drop_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [PW-1:0]                    rd_q, rd_d, wr_q, wr_d;
    logic [PW-1:0]                    tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    fetch_ent_t [FIFO_DEPTH-1:0]      fifo_q, fifo_d;
    logic [FIFO_DEPTH-1:0][XLEN-1:0]  tag_q, tag_d;

    logic            credit_ok;
    logic            rsp_keep;
    logic            rsp_cnt;
    logic            jal_hit;
    logic [XLEN-1:0] jal_target;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_ent_t      head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // A response only becomes an instruction when no stale words remain to be discarded.
    assign rsp_keep = imem_rvalid && (drop_q == '0) && !flush;
    assign rsp_cnt  = imem_rvalid && (out_q != '0);

`ifdef IF_JAL_PREDICT_EN
    assign jal_hit    = rsp_keep && (imem_rdata[6:0] == 7'b1101111);
    assign jal_target = tag_q[tag_rd_q] + {{(XLEN-20){imem_rdata[31]}}, imem_rdata[19:12],
                                           imem_rdata[20], imem_rdata[30:21], 1'b0};
`else
    assign jal_hit    = 1'b0;
    assign jal_target = '0;
`endif

    assign credit_ok = ({1'b0, cnt_q} + {1'b0, out_q}) < CREDITS;
    assign imem_req  = !rst && !flush && !jal_hit && credit_ok;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    assign head           = fifo_q[rd_q];
    assign if_valid       = !rst && (cnt_q != '0);
    assign if_pc_out      = if_valid ? head.pc : '0;
    assign if_instruction = if_valid ? head.ins : NOP;
    assign push           = rsp_keep;
    assign pop            = if_valid && !stall && !flush;

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + CW'(accept) - CW'(rsp_cnt);
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;
        fifo_d   = fifo_q;
        tag_d    = tag_q;

        if (flush) begin
            // Everything still in flight after this cycle belongs to the abandoned path.
            pc_d     = flush_pc & ALIGN_MASK;
            drop_d   = out_d;
            cnt_d    = '0;
            rd_d     = '0;
            wr_d     = '0;
            tag_rd_d = '0;
            tag_wr_d = '0;
        end else begin
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                fifo_d[wr_q].pc  = tag_q[tag_rd_q];
                fifo_d[wr_q].ins = imem_rdata;
                wr_d             = ptr_inc(wr_q);
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);

            if (jal_hit) begin
                // Requests issued past the JAL are wrong-path; discard them as they return.
                pc_d     = jal_target;
                drop_d   = out_d;
                tag_rd_d = '0;
                tag_wr_d = '0;
            end else begin
                if (accept) begin
                    pc_d            = pc_q + XLEN'(4);
                    tag_d[tag_wr_q] = pc_q;
                    tag_wr_d        = ptr_inc(tag_wr_q);
                end
                if (push) begin
                    tag_rd_d = ptr_inc(tag_rd_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
            fifo_q   <= '0;
            tag_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
            fifo_q   <= fifo_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
// Directed + randomized bench for if_fetch_unit against an in-order memory and a PC-stream reference model.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h30;
`else
    localparam logic [31:0] JAL_NEXT = 32'h14;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc_out;
    logic [31:0] if_instruction;

    always #5 clk = ~clk;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .if_valid       (if_valid),
        .if_pc_out      (if_pc_out),
        .if_instruction (if_instruction)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          lat_cfg  = 1;
    int          ready_pct = 100;
    logic [31:0] exp_pc   = '0;
    logic [31:0] addr_q[$];
    int          wait_q[$];
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_ins;
    logic        r_r, r_st, r_fl;
    logic [31:0] r_fpc;
    logic [31:0] seen [3];
    logic [31:0] held, after_jal, first_pc;
    int          got;
    logic        saw10;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h10) return 32'h0200_006F;
        w = a * 32'h9E37_79B9 + 32'h1234_5678;
        w[6:0] = 7'b0010011;
        return w;
    endfunction

    // Program order: sequential, except a taken JAL when prediction is built in.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
`ifdef IF_JAL_PREDICT_EN
        logic [31:0] w;
        w = mem_word(pc);
        if (w[6:0] == 7'b1101111)
            return pc + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
`endif
        return pc + 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs and memory response, sample, check, advance models.
    task automatic cycle(input logic r, input logic st, input logic fl, input logic [31:0] fpc);
        rst        = r;
        stall      = st;
        flush      = fl;
        flush_pc   = fpc;
        imem_ready = ($urandom_range(99) < ready_pct);
        if (r) begin
            addr_q.delete();
            wait_q.delete();
        end
        foreach (wait_q[i]) if (wait_q[i] > 0) wait_q[i]--;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!r && addr_q.size() > 0 && wait_q[0] == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(addr_q[0]);
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_pc    = if_pc_out;
        s_ins   = if_instruction;
        if (r) begin
            chk("rst_req", 32'(s_req), 32'd0);
            chk("rst_valid", 32'(s_valid), 32'd0);
            chk("rst_pc", s_pc, 32'd0);
            chk("rst_ins", s_ins, NOP);
        end else begin
            if (fl) chk("flush_req", 32'(s_req), 32'd0);
            if (s_valid) begin
                chk("out_pc", s_pc, exp_pc);
                chk("out_ins", s_ins, mem_word(exp_pc));
            end else begin
                chk("idle_ins", s_ins, NOP);
            end
        end
        if (r)                     exp_pc = 32'h0;
        else if (fl)               exp_pc = fpc & ~32'h3;
        else if (s_valid && !st)   exp_pc = next_pc(exp_pc);
        if (imem_rvalid) begin
            void'(addr_q.pop_front());
            void'(wait_q.pop_front());
        end
        if (!r && s_req && imem_ready) begin
            addr_q.push_back(s_addr);
            wait_q.push_back(lat_cfg);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset, then first fetches in order from RESET_PC.
        ready_pct = 100; lat_cfg = 1;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("t1_first_req", 32'(s_req), 32'd1);
        chk("t1_first_addr", s_addr, 32'h0);
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            cycle(0, 0, 0, 0);
            if (s_valid) begin
                seen[got] = s_pc;
                got++;
            end
        end
        chk("t1_count", 32'(got), 32'd3);
        chk("t1_pc0", seen[0], 32'h0);
        chk("t1_pc1", seen[1], 32'h4);
        chk("t1_pc2", seen[2], 32'h8);

        // JAL at 0x10: predicted target vs sequential successor.
        saw10 = 1'b0; after_jal = '1;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, 0, 0);
            if (s_valid && saw10) begin
                after_jal = s_pc;
                break;
            end
            if (s_valid && s_pc == 32'h10) saw10 = 1'b1;
        end
        chk("t6_after_jal", after_jal, JAL_NEXT);

        // Stall with a filling buffer: head held, requests stop when full.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0);
            if (s_valid) break;
        end
        held = '0;
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 1, 0, 0);
            if (i == 2) held = s_pc;
            if (i >= 3) begin
                chk("t2_valid_held", 32'(s_valid), 32'd1);
                chk("t2_pc_held", s_pc, held);
            end
        end
        chk("t2_req_full", 32'(s_req), 32'd0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);

        // Two requests in flight at latency 3, then redirect to 0x102.
        ready_pct = 0;
        cycle(0, 0, 1, 32'h200);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        ready_pct = 100; lat_cfg = 3;
        cycle(0, 0, 0, 0);
        chk("t3_req_a", s_addr, 32'h200);
        cycle(0, 0, 0, 0);
        chk("t3_req_b", s_addr, 32'h204);
        cycle(0, 0, 1, 32'h102);
        cycle(0, 0, 0, 0);
        chk("t3_valid_after_flush", 32'(s_valid), 32'd0);
        first_pc = '1;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0);
            if (s_valid) begin
                first_pc = s_pc;
                break;
            end
        end
        chk("t3_first_pc", first_pc, 32'h100);

        // Memory not ready: request and address held, PC not advanced.
        ready_pct = 0;
        cycle(0, 0, 1, 32'h40);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            chk("t4_req", 32'(s_req), 32'd1);
            chk("t4_addr", s_addr, 32'h40);
            chk("t4_valid", 32'(s_valid), 32'd0);
        end
        ready_pct = 100; lat_cfg = 1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

        // Flush beats stall with a full buffer.
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
        chk("t5_full_valid", 32'(s_valid), 32'd1);
        chk("t5_full_req", 32'(s_req), 32'd0);
        cycle(0, 1, 1, 32'h80);
        cycle(0, 1, 0, 0);
        chk("t5_valid_after", 32'(s_valid), 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);

        // Randomized traffic, including address wrap and occasional reset.
        ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            lat_cfg = $urandom_range(1, 4);
            r_r     = ($urandom_range(299) == 0);
            r_st    = ($urandom_range(3) == 0);
            r_fl    = ($urandom_range(39) == 0);
            r_fpc   = ($urandom_range(1) == 1) ? 32'($urandom_range(0, 160))
                                               : 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            cycle(r_r, r_st, r_fl, r_fpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
